// File: rtl/j_i2s_pkg.sv
// Shared types and constants for the Jerry I2S receive front-end.
package j_i2s_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ALIGN    = 2'd1,
    RUN      = 2'd2
  } rx_state_t;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/j_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a rising-edge pulse
// derived from the synchronised value.
module j_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              q_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync   <= '0;
      q_prev <= 1'b0;
    end else begin
      sync   <= {sync[STAGES-2:0], d};
      q_prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~q_prev;

endmodule

// File: rtl/j_i2s_rx.sv
// I2S serial audio receiver: synchronises sck/ws/sd, assembles MSB-first words
// into left/right holding registers. Optional sticky overrun flag: J_I2S_RX_OVERRUN_EN.
module j_i2s_rx
  import j_i2s_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              sck_in,
  input  logic              ws_in,
  input  logic              sd_in,
  input  logic              rx_en,
  input  logic              rd_l,
  input  logic              rd_r,
  output logic [WORD_W-1:0] left_data,
  output logic [WORD_W-1:0] right_data,
  output logic              left_valid,
  output logic              right_valid,
  output logic              irq
`ifdef J_I2S_RX_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [WORD_W-1:0] MSB_ONE = {1'b1, {(WORD_W-1){1'b0}}};

  rx_state_t         state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_ins;
  logic              ws_last;

  logic sck_s, bit_ev;
  logic ws_s, sd_s;
  logic ws_rise_unused, sd_rise_unused;
  logic ws_change, slot_free;
  logic latch_l, latch_r;

  // ws and sd use the same synchroniser as sck so all three see equal delay.
  j_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(sys_clk), .reset(reset), .d(sck_in), .q(sck_s), .rise(bit_ev)
  );
  j_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ws (
    .clk(sys_clk), .reset(reset), .d(ws_in), .q(ws_s), .rise(ws_rise_unused)
  );
  j_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sd (
    .clk(sys_clk), .reset(reset), .d(sd_in), .q(sd_s), .rise(sd_rise_unused)
  );

  assign ws_change = (ws_s != ws_last);
  assign slot_free = (cnt < CNT_W'(WORD_W));

  // The target bit is always still zero, so OR-ing the shifted marker inserts sd.
  always_comb begin
    sreg_ins = sreg;
    if (slot_free && sd_s)
      sreg_ins = sreg | (MSB_ONE >> cnt);
  end

  assign latch_l = rx_en && (state == RUN) && bit_ev && ws_change && (ws_last == WS_LEFT);
  assign latch_r = rx_en && (state == RUN) && bit_ev && ws_change && (ws_last == WS_RIGHT);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      state <= DISABLED;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!rx_en) begin
      state_next = DISABLED;
    end else begin
      case (state)
        DISABLED: state_next = ALIGN;
        ALIGN:    if (bit_ev && ws_change) state_next = RUN;
        RUN:      state_next = RUN;
        default:  state_next = DISABLED;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      sreg        <= '0;
      ws_last     <= WS_LEFT;
      left_data   <= '0;
      right_data  <= '0;
      left_valid  <= 1'b0;
      right_valid <= 1'b0;
      irq         <= 1'b0;
    end else if (!rx_en) begin
      cnt         <= '0;
      sreg        <= '0;
      left_valid  <= 1'b0;
      right_valid <= 1'b0;
      irq         <= 1'b0;
    end else begin
      irq <= latch_r;
      if (bit_ev && (state != DISABLED))
        ws_last <= ws_s;

      if (state != RUN) begin
        cnt  <= '0;
        sreg <= '0;
      end else if (bit_ev) begin
        if (ws_change) begin
          cnt  <= '0;
          sreg <= '0;
        end else if (slot_free) begin
          cnt  <= cnt + CNT_W'(1);
          sreg <= sreg_ins;
        end
      end

      if (latch_l) left_data  <= sreg_ins;
      if (latch_r) right_data <= sreg_ins;
      // A latch in the same cycle as a read wins, so the new word stays unread.
      left_valid  <= latch_l | (left_valid  & ~rd_l);
      right_valid <= latch_r | (right_valid & ~rd_r);
    end
  end

`ifdef J_I2S_RX_OVERRUN_EN
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (!rx_en)
      overrun <= 1'b0;
    else if ((latch_l && left_valid && !rd_l) || (latch_r && right_valid && !rd_r))
      overrun <= 1'b1;
  end
`endif

endmodule

// File: doc/j_i2s_rx.md
# j_i2s_rx

Serial audio receive front-end for Jerry. Takes an external I2S bit clock, word select and serial data, synchronises them into the `sys_clk` domain, and assembles MSB-first words. Completed left and right samples go into holding registers with valid flags and a frame interrupt. It feeds the load-enabled sync registers and the DSP-side sample latches downstream.

## Interface
Parameters:
- `WORD_W`, 16, bits captured per channel word
- `SYNC_STAGES`, 2, synchroniser depth for `sck_in`, `ws_in` and `sd_in` (minimum 2)

Ports:
- `sys_clk`  in  1  single system clock; all state is clocked on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sck_in`  in  1  external I2S bit clock (asynchronous)
- `ws_in`  in  1  external word select: 0 = left, 1 = right (asynchronous)
- `sd_in`  in  1  external serial data (asynchronous)
- `rx_en`  in  1  receiver enable
- `rd_l`  in  1  one-cycle read strobe; clears `left_valid`
- `rd_r`  in  1  one-cycle read strobe; clears `right_valid`
- `left_data`  out  WORD_W  last completed left word
- `right_data`  out  WORD_W  last completed right word
- `left_valid`  out  1  left word unread
- `right_valid`  out  1  right word unread
- `irq`  out  1  one-cycle pulse when a right word is latched
- `overrun`  out  1  sticky overrun flag (present only with `J_I2S_RX_OVERRUN_EN`)

## Operation
- Each input passes through `SYNC_STAGES` flops. A bit event is a rising edge on synchronised `sck`, i.e. the current sync value is 1 and the previous one was 0. At each bit event the block samples synchronised `ws` and `sd`.
- States:
  - DISABLED: entered from reset or when `rx_en`=0. Counter and shift register are zero.
  - ALIGN: entered when `rx_en`=1. Waits for a bit event where `ws` differs from `ws_last`. That first partial word is discarded and the block moves to RUN.
  - RUN: normal capture.
- Capture in RUN, per bit event:
  - If `ws` equals `ws_last`: when `cnt`<WORD_W, write `sreg[WORD_W-1-cnt]`=`sd` and increment `cnt`. When `cnt` has reached WORD_W, ignore the bit; excess bits are truncated.
  - If `ws` differs from `ws_last`: this bit is the LSB slot of the old word. Store it as above if `cnt`<WORD_W. Latch the word into the holding register of channel `ws_last`, set that channel's valid flag, then clear `sreg` and `cnt`.
  - Short words are MSB-justified, with zeros in the low bits.
- `ws_last` updates on every bit event in ALIGN and RUN.
- `irq` pulses for one cycle when a right-channel word is latched.
- Valid flags: the read strobe clears the flag. If a latch and the strobe for the same channel occur in the same cycle, valid ends at 1.
- `rx_en` falling: go to DISABLED on the next clock and clear both valid flags. `left_data` and `right_data` hold their values.

## Timing
- Reset value of every output is 0. The FSM resets to DISABLED and `ws_last` resets to 0.
- Latency from a pin `sck` rise to the bit event is SYNC_STAGES+1 `sys_clk` cycles, with ±1 cycle of sampling uncertainty.
- A latch is visible on `*_data`, `*_valid` and `irq` one cycle after the bit event.
- External `sck` high and low phases must each be at least SYNC_STAGES+1 `sys_clk` periods. Faster clocks are out of spec and produce no defined data.
- Reset asserted mid-word discards the partial word immediately.

## Configuration
- `J_I2S_RX_OVERRUN_EN` defined:
  - `overrun` port exists.
  - It is set when a latch hits a channel whose valid=1 and no read strobe for that channel occurs in the same cycle.
  - It is cleared only by `reset` or `rx_en`=0.
- Not defined:
  - The port and its logic are absent.
  - A latch into a channel that is still valid silently overwrites the data.

## Structure
- Package `j_i2s_pkg` holds:
  - the state enum (DISABLED, ALIGN, RUN)
  - constants `WS_LEFT`=0 and `WS_RIGHT`=1
- Sub-module `j_sync_edge`: SYNC_STAGES-deep synchroniser plus rising-edge pulse. It is instantiated for `sck`. `ws` and `sd` use the same module with the edge output unused, so their delays match.

## Test plan
- Reset: assert `reset` mid-stream. All outputs read 0 and the state is DISABLED; after release with `rx_en`=1, the first partial word is discarded.
- Normal frame, WORD_W=16:
  - Stimulus: left 0xA5C3 then right 0x1234 in standard I2S framing.
  - Left latch: `left_data`=0xA5C3 and `left_valid`=1.
  - Right latch: `right_data`=0x1234, `right_valid`=1, and one `irq` pulse.
- Word length mismatch:
  - 24-bit slot carrying 0xABCDEF: `left_data`=0xABCD (truncated).
  - 12-bit slot carrying 0xFFF: `left_data`=0xFFF0 (MSB-justified).
- Read collision: `rd_l` in the same cycle as a new left latch leaves `left_valid`=1 and `left_data` holding the new word.
- Overrun (macro on):
  - Two left words with no `rd_l`: `overrun`=1.
  - `rd_l` alone leaves `overrun`=1; `rx_en`=0 clears it.
- Macro off: same stimulus silently replaces `left_data` with the second word and no overrun indication.
- Enable drop: `rx_en`=0 mid-word, then re-enable. Valid flags clear, data is held, and the first word after re-enable is discarded (ALIGN).
